// File: rtl/segre_store_buffer_coalescing.sv
// Coalescing store buffer: word-aligned entries with byte enables, youngest-entry merge, byte-accurate load forwarding.
// Latency: load lookup is combinational on registered contents; a store is visible to loads from the next cycle.
// Backpressure: store_stall_o when full and no merge; head drains over flush_valid_o/flush_ack_i, held until acked.
module segre_store_buffer_coalescing #(
    parameter int NUM_ELEMS = 4,
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
) (
    input  logic                             clk_i,
    input  logic                             rsn_i,
    input  logic                             req_store_i,
    input  logic                             req_load_i,
    input  logic [ADDR_SIZE-1:0]             addr_i,
    input  logic [WORD_SIZE-1:0]             data_i,
    input  logic [1:0]                       memop_data_type_i,
    output logic                             store_stall_o,
    output logic                             hit_o,
    output logic                             miss_o,
    output logic                             trouble_o,
    output logic [WORD_SIZE-1:0]             data_load_o,
    input  logic                             flush_chance_i,
    input  logic                             drain_all_i,
    output logic                             flush_valid_o,
    input  logic                             flush_ack_i,
    output logic [ADDR_SIZE-1:0]             flush_addr_o,
    output logic [WORD_SIZE-1:0]             flush_data_o,
    output logic [WORD_SIZE/8-1:0]           flush_be_o,
    output logic                             empty_o,
    output logic                             full_o,
    output logic [$clog2(NUM_ELEMS+1)-1:0]   count_o
);

    localparam int NB = WORD_SIZE / 8;
    localparam int PW = $clog2(NUM_ELEMS);
    localparam int CW = $clog2(NUM_ELEMS + 1);
    localparam int WA = ADDR_SIZE - 2;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef logic [PW-1:0] ptr_t;

    // Entry storage; valid entries are always the contiguous run starting at head.
    logic [NUM_ELEMS-1:0] r_valid;
    logic [WA-1:0]        r_waddr [NUM_ELEMS];
    logic [WORD_SIZE-1:0] r_data  [NUM_ELEMS];
    logic [NB-1:0]        r_be    [NUM_ELEMS];
    ptr_t                 r_head;
    ptr_t                 r_tail;
    logic [CW-1:0]        r_count;

    logic [1:0]           w_off;
    logic [WA-1:0]        w_waddr;
    logic [NB-1:0]        w_req_be;
    logic [WORD_SIZE-1:0] w_shift_data;
    logic [WORD_SIZE-1:0] w_lane_data;
    logic                 w_empty;
    logic                 w_full;
    ptr_t                 w_young;
    logic                 w_flush_vld;
    logic                 w_merge;
    logic                 w_push;
    logic                 w_pop;
    logic [NB-1:0]        w_cov;
    logic [WORD_SIZE-1:0] w_fwd;
    logic                 w_all_cov;
    logic                 w_none_cov;
    logic                 w_misaligned;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic ptr_t f_inc(input ptr_t p);
        if (p == ptr_t'(NUM_ELEMS - 1)) begin
            return '0;
        end
        return p + ptr_t'(1);
    endfunction

    function automatic ptr_t f_dec(input ptr_t p);
        if (p == '0) begin
            return ptr_t'(NUM_ELEMS - 1);
        end
        return p - ptr_t'(1);
    endfunction

    assign w_off        = addr_i[1:0];
    assign w_waddr      = addr_i[ADDR_SIZE-1:2];
    assign w_shift_data = data_i << {w_off, 3'b000};

    // Byte enables of the request, positioned in lanes by the low address bits.
    always_comb begin
        w_req_be = '0;
        case (memop_data_type_i)
            MEM_BYTE: w_req_be = NB'(1) << w_off;
            MEM_HALF: w_req_be = NB'(3) << w_off;
            default:  w_req_be = '1;
        endcase
    end

    // Store data with disabled lanes zeroed, so fresh entries carry no stray bytes.
    always_comb begin
        w_lane_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (w_req_be[b]) begin
                w_lane_data[8*b +: 8] = w_shift_data[8*b +: 8];
            end
        end
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(NUM_ELEMS));
    assign w_young     = f_dec(r_tail);
    assign w_flush_vld = !w_empty && (flush_chance_i || drain_all_i);

    // The head is frozen while presented to the cache, so it cannot absorb a merge then.
    assign w_merge = req_store_i && !w_empty && r_valid[w_young] &&
                     (r_waddr[w_young] == w_waddr) &&
                     !((w_young == r_head) && w_flush_vld);
    assign w_push  = req_store_i && !w_merge && !w_full;
    assign w_pop   = w_flush_vld && flush_ack_i;

    assign store_stall_o = req_store_i && !w_merge && w_full;

    // Walk entries oldest to youngest so the youngest matching byte wins.
    always_comb begin
        ptr_t v_p;
        w_cov = '0;
        w_fwd = '0;
        v_p   = r_head;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            if (r_valid[v_p] && (r_waddr[v_p] == w_waddr)) begin
                for (int b = 0; b < NB; b++) begin
                    if (r_be[v_p][b] && w_req_be[b]) begin
                        w_cov[b]          = 1'b1;
                        w_fwd[8*b +: 8]   = r_data[v_p][8*b +: 8];
                    end
                end
            end
            v_p = f_inc(v_p);
        end
    end

    assign w_all_cov  = (w_cov == w_req_be);
    assign w_none_cov = (w_cov == '0);

    assign hit_o       = req_load_i && w_all_cov;
    assign miss_o      = req_load_i && w_none_cov;
    assign trouble_o   = req_load_i && !w_all_cov && !w_none_cov;
    assign data_load_o = hit_o ? (w_fwd >> {w_off, 3'b000}) : '0;

    assign flush_valid_o = w_flush_vld;
    assign flush_addr_o  = {r_waddr[r_head], 2'b00};
    assign flush_data_o  = r_data[r_head];
    assign flush_be_o    = r_be[r_head];

    assign empty_o = w_empty;
    assign full_o  = w_full;
    assign count_o = r_count;

    // Merge into youngest, allocate at tail, retire head on ack.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < NUM_ELEMS; i++) begin
                r_waddr[i] <= '0;
                r_data[i]  <= '0;
                r_be[i]    <= '0;
            end
        end else begin
            if (w_merge) begin
                for (int b = 0; b < NB; b++) begin
                    if (w_req_be[b]) begin
                        r_data[w_young][8*b +: 8] <= w_lane_data[8*b +: 8];
                    end
                end
                r_be[w_young] <= r_be[w_young] | w_req_be;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_waddr[r_tail] <= w_waddr;
                r_data[r_tail]  <= w_lane_data;
                r_be[r_tail]    <= w_req_be;
                r_tail          <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= f_inc(r_head);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign w_misaligned = (memop_data_type_i == 2'd3) ||
                          ((memop_data_type_i == MEM_HALF) && addr_i[0]) ||
                          ((memop_data_type_i == MEM_WORD) && (addr_i[1:0] != 2'b00));

    a_aligned: assert property (@(posedge clk_i) disable iff (!rsn_i)
        (req_store_i || req_load_i) |-> !w_misaligned);

    a_count_range: assert property (@(posedge clk_i) disable iff (!rsn_i)
        r_count <= CW'(NUM_ELEMS));

endmodule

// File: tb/tb_segre_store_buffer_coalescing.sv
module tb_segre_store_buffer_coalescing;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rsn_i;
    logic        req_store_i, req_load_i;
    logic [31:0] addr_i, data_i;
    logic [1:0]  memop_data_type_i;
    logic        store_stall_o, hit_o, miss_o, trouble_o;
    logic [31:0] data_load_o;
    logic        flush_chance_i, drain_all_i, flush_valid_o, flush_ack_i;
    logic [31:0] flush_addr_o, flush_data_o;
    logic [3:0]  flush_be_o;
    logic        empty_o, full_o;
    logic [2:0]  count_o;

    segre_store_buffer_coalescing #(.NUM_ELEMS(N), .ADDR_SIZE(32), .WORD_SIZE(32)) dut (
        .clk_i(clk), .rsn_i(rsn_i),
        .req_store_i(req_store_i), .req_load_i(req_load_i),
        .addr_i(addr_i), .data_i(data_i), .memop_data_type_i(memop_data_type_i),
        .store_stall_o(store_stall_o), .hit_o(hit_o), .miss_o(miss_o), .trouble_o(trouble_o),
        .data_load_o(data_load_o), .flush_chance_i(flush_chance_i), .drain_all_i(drain_all_i),
        .flush_valid_o(flush_valid_o), .flush_ack_i(flush_ack_i), .flush_addr_o(flush_addr_o),
        .flush_data_o(flush_data_o), .flush_be_o(flush_be_o),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of buffered words, oldest first.
    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    typedef struct {
        int          cnt;
        bit          emp, ful, fv, stall, hit, miss, trb;
        logic [31:0] dl, fa, fd;
        logic [3:0]  fbe;
    } exp_t;

    ent_t mq[$];
    exp_t sq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = be[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // One clock cycle of stimulus: drive at negedge, predict, queue the prediction, advance the model.
    task automatic cyc(input bit rst, input bit st, input bit ld, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] typ,
                       input bit chance, input bit drain, input bit ack);
        exp_t        e;
        logic [3:0]  nbe, cov;
        logic [31:0] ndat, fwd;
        int          off, sz;
        bit          merge, found;
        ent_t        t;
        @(negedge clk);
        rsn_i = !rst; req_store_i = st; req_load_i = ld; addr_i = addr; data_i = data;
        memop_data_type_i = typ; flush_chance_i = chance; drain_all_i = drain; flush_ack_i = ack;
        if (rst) mq.delete();
        off  = int'(addr[1:0]);
        nbe  = (typ == 2'd0) ? (4'b0001 << off) : (typ == 2'd1) ? (4'b0011 << off) : 4'b1111;
        ndat = (data << (8 * off)) & bmask(nbe);
        sz   = mq.size();
        e = '{default: 0};
        e.cnt = sz; e.emp = (sz == 0); e.ful = (sz == N);
        e.fv  = (sz > 0) && (chance || drain);
        if (e.fv) begin
            e.fa = {mq[0].w, 2'b00}; e.fd = mq[0].d; e.fbe = mq[0].be;
        end
        merge   = st && sz > 0 && mq[sz-1].w == addr[31:2] && !(sz == 1 && e.fv);
        e.stall = st && !merge && sz == N;
        if (ld) begin
            cov = 4'b0; fwd = 32'h0;
            for (int b = 0; b < 4; b++) begin
                found = 0;
                if (nbe[b]) begin
                    for (int i = sz - 1; i >= 0 && !found; i--) begin
                        if (mq[i].w == addr[31:2] && mq[i].be[b]) begin
                            found = 1; cov[b] = 1'b1; fwd[8*b +: 8] = mq[i].d[8*b +: 8];
                        end
                    end
                end
            end
            e.hit  = (cov == nbe);
            e.miss = (cov == 4'b0);
            e.trb  = !e.hit && !e.miss;
            e.dl   = e.hit ? (fwd >> (8 * off)) : 32'h0;
        end
        sq.push_back(e);
        if (!rst) begin
            if (merge) begin
                t = mq[sz-1];
                t.d  = (t.d & ~bmask(nbe)) | ndat;
                t.be = t.be | nbe;
                mq[sz-1] = t;
            end else if (st && sz < N) begin
                t.w = addr[31:2]; t.d = ndat; t.be = nbe;
                mq.push_back(t);
            end
            if (e.fv && ack) void'(mq.pop_front());
        end
    endtask

    task automatic do_st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] typ);
        cyc(0, 1, 0, a, d, typ, 0, 0, 0);
    endtask

    task automatic do_ld(input logic [31:0] a, input logic [1:0] typ);
        cyc(0, 0, 1, a, 32'h0, typ, 0, 0, 0);
    endtask

    task automatic drain_out();
        int guard = 0;
        while (mq.size() > 0 && guard < 20) begin
            cyc(0, 0, 0, 32'h0, 32'h0, 2'd2, 0, 1, 1);
            guard++;
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, pop one prediction and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("count",   count_o,       e.cnt);
                chk("empty",   empty_o,       e.emp);
                chk("full",    full_o,        e.ful);
                chk("fvalid",  flush_valid_o, e.fv);
                chk("stall",   store_stall_o, e.stall);
                chk("hit",     hit_o,         e.hit);
                chk("miss",    miss_o,        e.miss);
                chk("trouble", trouble_o,     e.trb);
                chk("ldata",   data_load_o,   e.dl);
                if (e.fv) begin
                    chk("faddr", flush_addr_o, e.fa);
                    chk("fbe",   flush_be_o,   e.fbe);
                    chk("fdata", flush_data_o & bmask(e.fbe), e.fd & bmask(e.fbe));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  typ;
        bit          rst, st, ld;
        rsn_i = 0; req_store_i = 0; req_load_i = 0; addr_i = 0; data_i = 0;
        memop_data_type_i = 0; flush_chance_i = 0; drain_all_i = 0; flush_ack_i = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Word store then full-word forward.
        do_st(32'h100, 32'hDEADBEEF, 2'd2);
        do_ld(32'h100, 2'd2);
        #2 chk("dir_word_fwd", data_load_o, 32'hDEADBEEF);
        drain_out();

        // Two byte stores to one word coalesce into one entry.
        do_st(32'h201, 32'h000000AA, 2'd0);
        do_st(32'h203, 32'h000000BB, 2'd0);
        do_ld(32'h202, 2'd1);
        #2 chk("dir_half_trouble", trouble_o, 1'b1);
        do_ld(32'h203, 2'd0);
        #2 chk("dir_byte_fwd", data_load_o, 32'h000000BB);
        chk("dir_merge_count", count_o, 3'd1);
        drain_out();

        // Fill, stall on a new word, merge into youngest while full, then ordered drain.
        for (int i = 0; i < 4; i++) do_st(32'(i * 16), 32'h1000 + 32'(i), 2'd2);
        do_st(32'h40, 32'h12345678, 2'd2);
        #2 chk("dir_full_stall", store_stall_o, 1'b1);
        do_st(32'h31, 32'h0000005A, 2'd0);
        #2 chk("dir_full_merge", store_stall_o, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 2'd2, 0, 1, 1);
            #2 chk("dir_drain_addr", flush_addr_o, 32'(i * 16));
        end
        cyc(0, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        #2 chk("dir_drained_empty", empty_o, 1'b1);

        // A head being presented refuses the merge.
        do_st(32'h50, 32'h11111111, 2'd2);
        cyc(0, 1, 0, 32'h50, 32'h22222222, 2'd2, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 2'd2, 1, 0, 1);
        #2 chk("dir_nomerge_count", count_o, 3'd2);
        chk("dir_nomerge_old", flush_data_o, 32'h11111111);
        cyc(0, 0, 0, 0, 0, 2'd2, 1, 0, 0);
        #2 chk("dir_nomerge_new", flush_data_o, 32'h22222222);
        drain_out();

        // Reset while draining.
        do_st(32'h60, 32'hA, 2'd2);
        do_st(32'h64, 32'hB, 2'd2);
        do_st(32'h68, 32'hC, 2'd2);
        cyc(0, 0, 0, 0, 0, 2'd2, 0, 1, 0);
        cyc(1, 0, 0, 0, 0, 2'd2, 0, 1, 1);
        #2 chk("dir_rst_fvalid", flush_valid_o, 1'b0);
        chk("dir_rst_count", count_o, 3'd0);
        cyc(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        do_ld(32'h65, 2'd0);
        #2 chk("dir_rst_miss", miss_o, 1'b1);

        // Randomised traffic over a handful of words to provoke merges and overlaps.
        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 4))
                0: a = 32'h100;
                1: a = 32'h104;
                2: a = 32'h108;
                3: a = 32'h10C;
                default: a = 32'h200;
            endcase
            typ = 2'($urandom_range(0, 2));
            if (typ == 2'd0) a = a + 32'($urandom_range(0, 3));
            else if (typ == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            st  = !rst && ($urandom_range(0, 1) == 1);
            ld  = !rst && ($urandom_range(0, 9) < 4);
            cyc(rst, st, ld, a, $urandom, typ,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6);
        end

        #5;
        chk("queue_drained", sq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
